// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide requester: request opcodes,
// unit control codes, FSM states and the opcode-to-control mapping.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } md_op_e;

  localparam logic [3:0] CTRL_MULT  = 4'h0;
  localparam logic [3:0] CTRL_MULTU = 4'h1;
  localparam logic [3:0] CTRL_DIV   = 4'h2;
  localparam logic [3:0] CTRL_DIVU  = 4'h3;
  localparam logic [3:0] CTRL_MTHI  = 4'h4;
  localparam logic [3:0] CTRL_MTLO  = 4'h5;
  localparam logic [3:0] CTRL_IDLE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_e;

  // MFHI/MFLO never reach the unit, so they map onto the hold code.
  function automatic logic [3:0] op_to_ctrl(input md_op_e op, input logic [3:0] idle_ctrl);
    logic [3:0] ctrl;
    case (op)
      OP_MULT:  ctrl = CTRL_MULT;
      OP_MULTU: ctrl = CTRL_MULTU;
      OP_DIV:   ctrl = CTRL_DIV;
      OP_DIVU:  ctrl = CTRL_DIVU;
      OP_MTHI:  ctrl = CTRL_MTHI;
      OP_MTLO:  ctrl = CTRL_MTLO;
      default:  ctrl = idle_ctrl;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/e_md_requester_if.sv
// Request, unit-drive and read-back signals of the MD requester.
// master = requester view, slave = pipeline/unit view.
interface e_md_requester_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        int_req;
  logic        md_start;
  logic [3:0]  md_ctrl;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_int_req;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        stall;
  logic        md_err;

  modport master (
    input  req_valid, req_op, req_a, req_b, int_req, md_busy, md_hi, md_lo,
    output req_ready, md_start, md_ctrl, md_a, md_b, md_int_req,
           rd_valid, rd_data, stall, md_err
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, int_req, md_busy, md_hi, md_lo,
    input  req_ready, md_start, md_ctrl, md_a, md_b, md_int_req,
           rd_valid, rd_data, stall, md_err
  );
endinterface

// File: rtl/md_wait_watchdog.sv
// WAIT-state watchdog: counts WAIT cycles, expire fires in the TIMEOUT-th still-busy
// cycle and err is a sticky flop cleared only by reset.
module md_wait_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic md_busy,
  output logic expire,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d  = '0;
    if (in_wait) cnt_d = cnt_q + 1'b1;
    expire = in_wait & md_busy & (cnt_q == CW'(TIMEOUT - 1));
    err_d  = err_q | expire;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
endmodule

// File: rtl/e_md_requester.sv
// E-stage MD requester: ISSUE outputs one cycle after accept, MFHI/MFLO data one cycle after accept;
// stalls the pipeline while issuing or unit busy. MD_WAIT_TIMEOUT_EN adds a WAIT watchdog driving md_err.
module e_md_requester #(
  parameter int         TIMEOUT   = 16,
  parameter logic [3:0] IDLE_CTRL = 4'hF
) (
  input logic              clk,
  input logic              reset,
  e_md_requester_if.master bus
);
  import md_pkg::*;

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic        md_start_q, md_start_d;
  logic [3:0]  md_ctrl_q, md_ctrl_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

  md_op_e req_op;
  logic   req_ready;
  logic   accept;
  logic   in_wait;
  logic   wd_expire;
  logic   wd_err;

  assign req_op    = md_op_e'(bus.req_op);
  assign req_ready = reset & (state_q == ST_IDLE) & ~bus.md_busy & ~bus.int_req;
  assign accept    = bus.req_valid & req_ready;
  assign in_wait   = (state_q == ST_WAIT);

`ifdef MD_WAIT_TIMEOUT_EN
  md_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .in_wait (in_wait),
    .md_busy (bus.md_busy),
    .expire  (wd_expire),
    .err     (wd_err)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, in_wait};
  assign wd_expire  = 1'b0;
  assign wd_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    md_start_d = 1'b0;
    md_ctrl_d  = IDLE_CTRL;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_op inside {OP_MFHI, OP_MFLO}) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (req_op == OP_MFHI) ? bus.md_hi : bus.md_lo;
          end else begin
            state_d    = ST_ISSUE;
            op_d       = req_op;
            md_start_d = ~bus.req_op[2];
            md_ctrl_d  = op_to_ctrl(req_op, IDLE_CTRL);
            md_a_d     = bus.req_a;
            md_b_d     = bus.req_b;
          end
        end
      end
      ST_ISSUE: begin
        // An interrupt here makes the unit drop the op, so nothing is left to wait for.
        if (bus.int_req || (op_q inside {OP_MTHI, OP_MTLO})) state_d = ST_IDLE;
        else                                                  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.md_busy || wd_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULT;
      md_start_q <= 1'b0;
      md_ctrl_q  <= IDLE_CTRL;
      md_a_q     <= '0;
      md_b_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      md_start_q <= md_start_d;
      md_ctrl_q  <= md_ctrl_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // md_int_req must accompany md_start in the ISSUE cycle itself for the unit to discard the op.
  assign bus.md_int_req = (state_q == ST_ISSUE) & bus.int_req;
  assign bus.req_ready  = req_ready;
  assign bus.stall      = bus.req_valid & ~req_ready;
  assign bus.md_start   = md_start_q;
  assign bus.md_ctrl    = md_ctrl_q;
  assign bus.md_a       = md_a_q;
  assign bus.md_b       = md_b_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.md_err     = wd_err;
endmodule

// File: tb/tb_e_md_requester.sv
// Bench for e_md_requester: behavioural MD unit model plus an MFHI/MFLO read-data scoreboard.
module tb_e_md_requester;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_md_requester_if bus();

  e_md_requester #(.TIMEOUT(16), .IDLE_CTRL(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } arith_t;

  arith_t arith_tbl[4] = '{
    '{3'd1, 32'hFFFFFFFE, 32'd3,      32'h00000002, 32'hFFFFFFFA, 7},
    '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 7},
    '{3'd2, 32'hFFFFFFEF, 32'd5,      32'hFFFFFFFE, 32'hFFFFFFFD, 12},
    '{3'd3, 32'hFFFFFFFF, 32'd10,     32'h00000005, 32'h19999999, 12}
  };

  // MD unit model: 5 busy cycles for multiply, 10 for divide, MTHI/MTLO written at end of ISSUE.
  logic [31:0] u_hi, u_lo;
  int          u_cnt = 0;
  logic        force_busy = 1'b0;

  assign bus.md_busy = (u_cnt != 0) | force_busy;
  assign bus.md_hi   = u_hi;
  assign bus.md_lo   = u_lo;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    int q, r;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {32'(r), 32'(q)};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      u_hi  <= '0;
      u_lo  <= '0;
      u_cnt <= 0;
    end else begin
      if (u_cnt != 0) u_cnt <= u_cnt - 1;
      if (!bus.md_int_req) begin
        if (bus.md_start) begin
          case (bus.md_ctrl)
            4'h0: begin {u_hi, u_lo} <= smul(bus.md_a, bus.md_b); u_cnt <= 5; end
            4'h1: begin {u_hi, u_lo} <= {32'b0, bus.md_a} * {32'b0, bus.md_b}; u_cnt <= 5; end
            4'h2: begin {u_hi, u_lo} <= sdiv(bus.md_a, bus.md_b); u_cnt <= 10; end
            4'h3: begin u_hi <= bus.md_a % bus.md_b; u_lo <= bus.md_a / bus.md_b; u_cnt <= 10; end
            default: ;
          endcase
        end else if (bus.md_ctrl == 4'h4) begin
          u_hi <= bus.md_a;
        end else if (bus.md_ctrl == 4'h5) begin
          u_lo <= bus.md_a;
        end
      end
    end
  end

  // Scoreboard: every rd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: unexpected rd_valid, got %h, none pending", bus.rd_data);
      end else begin
        if (bus.rd_data !== exp_q[0]) begin
          n_err++;
          $display("FAIL rd_data: got %h, want %h", bus.rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Holds the request until accepted; returns at mid-cycle N+1 with waits = cycles stalled.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int waits);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    waits = 0;
    #1;
    while (bus.req_ready !== 1'b1 && waits < 100) begin
      n_vec++;
      if (bus.stall !== 1'b1) begin
        n_err++;
        $display("FAIL stall: op %0d wait %0d got %b, want 1", op, waits, bus.stall);
      end
      @(negedge clk);
      #1;
      waits++;
    end
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout: op %0d req_ready %b after %0d cycles, want 1", op, bus.req_ready, waits);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b1;
    #1;
    n_vec++;
    if ({bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b, bus.md_int_req, bus.rd_valid, bus.rd_data,
         bus.md_err, bus.req_ready, bus.stall} !==
        {1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: start %b ctrl %h a %h b %h int %b rdv %b rdd %h err %b rdy %b stall %b, want 0 f 0 0 0 0 0 0 0 1",
               bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b, bus.md_int_req, bus.rd_valid, bus.rd_data,
               bus.md_err, bus.req_ready, bus.stall);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.stall} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: ready/stall %b, want 10", {bus.req_ready, bus.stall});
    end
  endtask

  task automatic test_mult();
    int w;
    send(OP_MULT, 32'hFFFFFFFE, 32'd3, w);
    n_vec++;
    if ({bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b} !== {1'b1, 4'h0, 32'hFFFFFFFE, 32'd3}) begin
      n_err++;
      $display("FAIL mult_issue: start %b ctrl %h a %h b %h, want 1 0 fffffffe 00000003",
               bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b);
    end
    for (int i = 1; i <= 7; i++) begin
      n_vec++;
      if (bus.req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL mult_ready_low: N+%0d got %b, want 0", i, bus.req_ready);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({bus.req_ready, bus.md_start, bus.md_ctrl} !== {1'b1, 1'b0, 4'hF}) begin
      n_err++;
      $display("FAIL mult_reaccept: ready %b start %b ctrl %h at N+8, want 1 0 f",
               bus.req_ready, bus.md_start, bus.md_ctrl);
    end
    exp_q.push_back(32'hFFFFFFFA);
    send(OP_MFLO, 32'h0, 32'h0, w);
    exp_q.push_back(32'hFFFFFFFF);
    send(OP_MFHI, 32'h0, 32'h0, w);
  endtask

  task automatic test_arith();
    int w;
    foreach (arith_tbl[k]) begin
      send(arith_tbl[k].op, arith_tbl[k].a, arith_tbl[k].b, w);
      exp_q.push_back(arith_tbl[k].lo);
      send(OP_MFLO, 32'h0, 32'h0, w);
      n_vec++;
      if (w != arith_tbl[k].lat) begin
        n_err++;
        $display("FAIL arith_latency: op %0d stalled %0d cycles, want %0d", arith_tbl[k].op, w, arith_tbl[k].lat);
      end
      exp_q.push_back(arith_tbl[k].hi);
      send(OP_MFHI, 32'h0, 32'h0, w);
    end
  endtask

  task automatic test_divu();
    int w;
    send(OP_DIVU, 32'd17, 32'd5, w);
    exp_q.push_back(32'd2);
    send(OP_MFHI, 32'h0, 32'h0, w);
    n_vec++;
    if (w != 12 || bus.rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL divu_mfhi: stalled %0d rd_valid %b, want 12 1", w, bus.rd_valid);
    end
    exp_q.push_back(32'd3);
    send(OP_MFLO, 32'h0, 32'h0, w);
  endtask

  task automatic test_mt_mf();
    int w;
    send(OP_MTLO, 32'h12345678, 32'h0, w);
    n_vec++;
    if ({bus.md_start, bus.md_ctrl, bus.md_a} !== {1'b0, 4'h5, 32'h12345678}) begin
      n_err++;
      $display("FAIL mtlo_issue: start %b ctrl %h a %h, want 0 5 12345678", bus.md_start, bus.md_ctrl, bus.md_a);
    end
    exp_q.push_back(32'h12345678);
    send(OP_MFLO, 32'h0, 32'h0, w);
    n_vec++;
    if ({w == 1, bus.rd_valid, bus.md_start} !== 3'b110) begin
      n_err++;
      $display("FAIL mtlo_mflo: stalled %0d rd_valid %b start %b, want 1 1 0", w, bus.rd_valid, bus.md_start);
    end
  endtask

  task automatic test_int_issue();
    int w;
    send(OP_DIV, 32'd100, 32'd7, w);
    bus.int_req = 1'b1;
    #1;
    n_vec++;
    if ({bus.md_start, bus.md_ctrl, bus.md_int_req} !== {1'b1, 4'h2, 1'b1}) begin
      n_err++;
      $display("FAIL int_issue: start %b ctrl %h md_int_req %b, want 1 2 1", bus.md_start, bus.md_ctrl, bus.md_int_req);
    end
    @(negedge clk);
    bus.int_req = 1'b0;
    #1;
    n_vec++;
    if ({bus.req_ready, bus.md_int_req, bus.md_ctrl, bus.md_start} !== {1'b1, 1'b0, 4'hF, 1'b0}) begin
      n_err++;
      $display("FAIL int_back_idle: ready %b md_int_req %b ctrl %h start %b, want 1 0 f 0",
               bus.req_ready, bus.md_int_req, bus.md_ctrl, bus.md_start);
    end
    exp_q.push_back(32'd2);
    send(OP_MFHI, 32'h0, 32'h0, w);
    exp_q.push_back(32'h12345678);
    send(OP_MFLO, 32'h0, 32'h0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [2:0]  ops  [3] = '{3'd6, 3'd7, 3'd6};
    logic [31:0] vals [3] = '{32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
    send(OP_MTHI, 32'hA5A5A5A5, 32'h0, w);
    exp_q.push_back(32'hA5A5A5A5);
    send(OP_MFHI, 32'h0, 32'h0, w);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      send(ops[i], 32'h0, 32'h0, w);
      n_vec++;
      if (w != 0 || bus.rd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_read: read %0d stalled %0d rd_valid %b, want 0 1", i, w, bus.rd_valid);
      end
    end
  endtask

  task automatic test_reset_wait();
    int w;
    send(OP_MULT, 32'd7, 32'd9, w);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b, bus.md_int_req, bus.rd_valid, bus.rd_data,
         bus.md_err, bus.req_ready, bus.stall} !==
        {1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_in_wait: start %b ctrl %h a %h b %h rdv %b err %b rdy %b stall %b, want 0 f 0 0 0 0 0 1",
               bus.md_start, bus.md_ctrl, bus.md_a, bus.md_b, bus.rd_valid, bus.md_err, bus.req_ready, bus.stall);
    end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_wait_idle: req_ready %b, want 1", bus.req_ready);
    end
    exp_q.push_back(32'h0);
    send(OP_MFLO, 32'h0, 32'h0, w);
  endtask

`ifdef MD_WAIT_TIMEOUT_EN
  task automatic test_watchdog();
    int w;
    force_busy = 1'b1;
    send(OP_MULT, 32'd1, 32'd1, w);
    repeat (16) @(negedge clk);
    n_vec++;
    if (bus.md_err !== 1'b0) begin
      n_err++;
      $display("FAIL wd_early: md_err %b at WAIT cycle 16, want 0", bus.md_err);
    end
    @(negedge clk);
    force_busy = 1'b0;
    #1;
    n_vec++;
    if ({bus.md_err, bus.req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL wd_expire: md_err/req_ready %b, want 11", {bus.md_err, bus.req_ready});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.md_err !== 1'b1) begin
      n_err++;
      $display("FAIL wd_sticky: md_err %b, want 1", bus.md_err);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_vec++;
    if (bus.md_err !== 1'b0) begin
      n_err++;
      $display("FAIL wd_reset: md_err %b, want 0", bus.md_err);
    end
  endtask
`endif

  initial begin
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.int_req   = 1'b0;
    test_reset();
    test_mult();
    test_arith();
    test_divu();
    test_mt_mf();
    test_int_issue();
    test_back_to_back();
    test_reset_wait();
`ifdef MD_WAIT_TIMEOUT_EN
    test_watchdog();
`endif
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d reads never returned, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/e_md_requester.md
# e_md_requester

- Pipeline-side initiator for the E-stage multiply/divide unit.
- Accepts HI/LO instructions (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO) from the E-stage control with a valid/ready handshake.
- Drives the unit's start/control/operand/interrupt inputs and tracks its busy counter.
- Returns MFHI/MFLO read data and produces the pipeline stall.

## Interface
- TIMEOUT, 16: WAIT-state cycle limit; only used with the watchdog compiled in.
- IDLE_CTRL, 4'hF: control code driven whenever no operation is being issued. It selects the unit's hold-HI/LO default case.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; while low, all state and outputs are cleared on the next edge.
- req_valid  in  1  request present.
- req_op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- req_a, req_b  in  32  rs/rt operands.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- int_req  in  1  interrupt/exception pending in the pipeline.
- md_start  out  1  start pulse to the unit.
- md_ctrl  out  4  unit control code.
- md_a, md_b  out  32  unit operands.
- md_int_req  out  1  interrupt forwarded to the unit.
- md_busy  in  1  unit busy.
- md_hi, md_lo  in  32  unit HI/LO registers.
- rd_valid  out  1  MFHI/MFLO data valid (one-cycle pulse).
- rd_data  out  32  MFHI/MFLO data.
- stall  out  1  equals req_valid & ~req_ready.
- md_err  out  1  sticky watchdog error.

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **Outputs:** md_start, md_ctrl, md_a, md_b, md_int_req, rd_valid, rd_data and md_err are all registered.
- **Reset values:**
  - state = IDLE; all outputs = 0, except md_ctrl = IDLE_CTRL.
  - stall follows req_valid, since req_ready = 0 during reset.
- **req_ready:** high only when state is IDLE, md_busy = 0 and int_req = 0.
- **IDLE, accepting op 0-5:**
  - Latch the operation; next state ISSUE.
  - In ISSUE: md_ctrl = op, md_a = req_a, md_b = req_b, md_int_req = int_req.
  - md_start = 1 for ops 0-3 and 0 for ops 4-5 (MTHI/MTLO need no start).
- **IDLE, accepting op 6/7:**
  - Next cycle: rd_data = md_hi (op 6) or md_lo (op 7), rd_valid = 1.
  - State stays IDLE.
- **ISSUE (exactly 1 cycle):**
  - md_busy is ignored in this cycle; the unit's counter loads at its end.
  - Ops 0-3 → WAIT. Ops 4-5 → IDLE.
  - If int_req = 1 in ISSUE: md_int_req = 1, so the unit discards the operation; next state IDLE.
- **WAIT:**
  - Hold until md_busy = 0 is sampled, then → IDLE.
  - int_req does not abort WAIT; an in-flight operation cannot be cancelled.
- **Idle drive:** whenever not in ISSUE, md_ctrl = IDLE_CTRL and md_start = 0. Leaving an opcode on md_ctrl is forbidden.
- **Widths:** operands pass through unmodified. Signedness is decided by the opcode inside the unit.

## Timing
- **Accept edge:** a request accepted in cycle N produces ISSUE outputs in cycle N+1. md_busy first rises in N+2.
- **MULT/MULTU:** next accept no earlier than N+8 (1 ISSUE + 5 busy + 1 IDLE re-check).
- **DIV/DIVU:** next accept no earlier than N+13.
- **MTHI/MTLO:** write HI/LO at the end of N+1. An MFHI/MFLO accepted in N+2 returns the new value in N+3.
- **MFHI/MFLO:** accepted in N, data in N+1. Back-to-back MF reads are accepted every cycle.
- **Reset mid-operation:** the requester returns to IDLE on the same edge. The unit is reset by the shared reset.

## Configuration
- **MD_WAIT_TIMEOUT_EN defined:**
  - A counter runs in WAIT.
  - If md_busy is still 1 after TIMEOUT WAIT cycles, md_err is set (sticky until reset) and the state forces to IDLE.
- **MD_WAIT_TIMEOUT_EN undefined:** no counter; md_err is tied to 0; WAIT is unbounded.

## Structure
- **Package md_pkg:**
  - req_op codes and the 4-bit md_ctrl codes (0-5 as listed, IDLE_CTRL = 4'hF).
  - State encoding (IDLE = 0, ISSUE = 1, WAIT = 2).
  - req_op → md_ctrl mapping function.
- **Sub-module md_wait_watchdog:**
  - Counter, compare and sticky error.
  - Instantiated only under MD_WAIT_TIMEOUT_EN.

## Test plan
- **MULT:** MULT a=0xFFFFFFFE, b=3 → md_start pulse with md_ctrl=0 in N+1; req_ready low N+1..N+7. Afterwards MFLO → 0xFFFFFFFA, MFHI → 0xFFFFFFFF.
- **DIVU:** DIVU a=17, b=5 followed by a queued MFHI → stall high until N+13. MFHI accepted at N+13, rd_data=2 at N+14.
- **MTLO then MFLO:** MTLO 0x12345678, then MFLO the next accepted cycle → md_start stays 0 throughout. rd_data=0x12345678, with rd_valid in the cycle after the MFLO accept.
- **Interrupt in ISSUE:** int_req asserted in the ISSUE cycle of a DIV → md_int_req=1, state back to IDLE. MFHI/MFLO return the old HI/LO.
- **Reset during WAIT:** reset low during WAIT of a MULT → all outputs at reset values on the next edge, md_ctrl=4'hF.
- **Watchdog (MD_WAIT_TIMEOUT_EN defined):** md_busy held high by the bench → md_err=1 after 16 WAIT cycles, req_ready returns high. md_err stays 1 until reset.
